stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6: payload width in bits.
REQ-002 SHALL have parameter A_WIDTH, default 2: requester index width.
REQ-003 SHALL have parameter BURST, default 4, legal range 1..15: maximum consecutive beats granted to one requester.
REQ-004 SHALL derive localparam N_REQ = 2**A_WIDTH: number of requesters.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk  input  1  rising-edge clock.
REQ-007 Port rst  input  1  asynchronous active-low reset.
REQ-008 Port up_data  input  N_REQ*D_WIDTH  packed payloads; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-009 Port up_valid  input  N_REQ  per-requester valid.
REQ-010 Port up_ready  output  N_REQ  per-requester ready.
REQ-011 Port down_data  output  D_WIDTH  registered winning payload.
REQ-012 Port down_src  output  A_WIDTH  index of the requester that supplied down_data.
REQ-013 Port down_valid  output  1  registered output valid.
REQ-014 Port down_ready  input  1  downstream ready.

Function
REQ-015 SHALL define a beat as transferred on a port when valid and ready are both high at a rising clk edge.
REQ-016 SHALL hold the output in a single register stage with load enable ld = !down_valid | down_ready; latency from up-beat to down_valid is 1 cycle.
REQ-017 SHALL sustain 1 beat per cycle while down_ready stays high and a grantable requester is valid.
REQ-018 SHALL assert at most one up_ready bit per cycle, and only when ld=1 and the selected requester has up_valid=1.
REQ-019 SHALL keep down_data and down_src stable while down_valid=1 and down_ready=0, with all up_ready=0.
REQ-020 SHALL implement FSM states ARB and LOCK, plus round-robin pointer ptr (A_WIDTH bits) and beat counter cnt (4 bits).
REQ-021 In ARB, the selected requester SHALL be the first i with up_valid[i]=1, searching from ptr upward with wrap N_REQ-1 -> 0.
REQ-022 On an ARB accept from requester i, ptr SHALL load (i+1) mod N_REQ.
REQ-023 On an ARB accept from requester i with BURST>1, the FSM SHALL move to LOCK with owner=i and cnt=1; with BURST=1 it SHALL stay in ARB.
REQ-024 In LOCK, only the owner SHALL be selectable; each owner accept SHALL increment cnt.
REQ-025 In LOCK, the FSM SHALL return to ARB on the owner accept that makes cnt equal BURST.
REQ-026 In LOCK, when ld=1 and up_valid[owner]=0, no up_ready SHALL be asserted that cycle and the FSM SHALL return to ARB (one bubble); ptr stays owner+1.
REQ-027 When ld=0, ptr, cnt and FSM state SHALL hold.
REQ-028 A requester SHALL NOT be starved: any continuously valid requester is accepted within N_REQ*BURST + N_REQ output beats.

Reset
REQ-029 While rst=0, SHALL force down_valid=0, down_data=0, down_src=0, ptr=0, cnt=0, state=ARB, and up_ready=0 asynchronously.
REQ-030 SHALL accept a beat on the first rising edge after rst deasserts.
REQ-031 Reset asserted mid-burst or with a pending output SHALL discard that beat; there is no recovery of in-flight data.

Structure
REQ-032 Package stream_arb_pkg SHALL hold the arb_state_t enum (ARB, LOCK) and the default D_WIDTH, A_WIDTH and BURST constants.
REQ-033 SHALL instantiate one combinational sub-module, rr_pick: rotating-priority encoder (inputs: request vector, ptr; outputs: found flag, index).

Verification (D_WIDTH=6, A_WIDTH=2, down_ready=1 unless stated)
REQ-034 Reset release, only up_valid[2]=1 with data 6'h15 -> up_ready[2]=1 in the same cycle; next cycle down_valid=1, down_data=6'h15, down_src=2.
REQ-035 BURST=1, all four requesters continuously valid -> down_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
REQ-036 BURST=4, all four requesters valid -> down_src sequence is four beats each of 0, 1, 2, 3, then repeats.
REQ-037 Hold down_ready=0 for 3 cycles while down_valid=1 -> down_data and down_src unchanged and up_ready=4'b0000 throughout; with a requester valid, a transfer occurs on the first cycle down_ready=1.
REQ-038 BURST=4, owner 1 drops up_valid after 2 beats, requester 3 valid -> one bubble cycle, then down_src=3 and ptr=0 after that accept.
REQ-039 rst=0 asserted mid-LOCK with down_valid=1 -> down_valid=0 before the next clk edge; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and default parameter values for the round-robin stream arbiter.
//   arb_state_t : arbitration FSM states (ARB = open arbitration,
//                 LOCK = burst ownership held by one requester)
//   DEF_*       : default payload width, index width and burst length
//   CNT_W       : width of the burst beat counter
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_D_WIDTH = 6;
    localparam int DEF_A_WIDTH = 2;
    localparam int DEF_BURST   = 4;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Returns the first asserted request
// found when scanning upward from ptr, wrapping from the top index back to 0.
// Ports:
//   req   [2**A_WIDTH-1:0] in  : request vector
//   ptr   [A_WIDTH-1:0]    in  : index with highest priority
//   found                  out : at least one request is asserted
//   index [A_WIDTH-1:0]    out : winning request index (0 when !found)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int A_WIDTH = 2
) (
    input  logic [2**A_WIDTH-1:0] req,
    input  logic [A_WIDTH-1:0]    ptr,
    output logic                  found,
    output logic [A_WIDTH-1:0]    index
);

    localparam int N_REQ = 2**A_WIDTH;

    logic [A_WIDTH-1:0] pos;

    // Scan from the farthest offset down to offset 0 so the nearest request
    // to ptr is the last one written and therefore wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + A_WIDTH'(k);
            if (req[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// N_REQ-input valid/ready stream arbiter with round-robin fairness and burst
// locking. A winner keeps the output for up to BURST consecutive beats; the
// winning payload is registered in a single output stage.
// Ports:
//   clk                           in  : rising-edge clock
//   rst                           in  : asynchronous active-low reset
//   up_data   [N_REQ*D_WIDTH-1:0] in  : packed payloads, lane i at [i*D_WIDTH +: D_WIDTH]
//   up_valid  [N_REQ-1:0]         in  : per-requester valid
//   up_ready  [N_REQ-1:0]         out : per-requester ready (at most one hot)
//   down_data [D_WIDTH-1:0]       out : registered winning payload
//   down_src  [A_WIDTH-1:0]       out : requester index of down_data
//   down_valid                    out : registered output valid
//   down_ready                    in  : downstream ready
// -----------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int BURST   = DEF_BURST
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(2**A_WIDTH)*D_WIDTH-1:0] up_data,
    input  logic [2**A_WIDTH-1:0]          up_valid,
    output logic [2**A_WIDTH-1:0]          up_ready,
    output logic [D_WIDTH-1:0]             down_data,
    output logic [A_WIDTH-1:0]             down_src,
    output logic                           down_valid,
    input  logic                           down_ready
);

    localparam int N_REQ = 2**A_WIDTH;
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    arb_state_t         state;
    logic [A_WIDTH-1:0] ptr;
    logic [A_WIDTH-1:0] owner;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;

    logic               pick_found;
    logic [A_WIDTH-1:0] pick_idx;
    logic [A_WIDTH-1:0] sel;
    logic               sel_ok;
    logic               ld;
    logic               grant;

    rr_pick #(
        .A_WIDTH (A_WIDTH)
    ) u_pick (
        .req   (up_valid),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Output stage can take a new beat when it is empty or being drained.
    assign ld      = !down_valid || down_ready;
    assign cnt_inc = cnt + 1'b1;

    // While locked only the owner is eligible; an idle owner yields no grant,
    // which produces the single bubble when a burst is abandoned.
    always_comb begin
        sel    = pick_idx;
        sel_ok = pick_found;
        if (state == LOCK) begin
            sel    = owner;
            sel_ok = up_valid[owner];
        end
    end

    // rst gates the grant so up_ready drops asynchronously with reset.
    assign grant = rst && ld && sel_ok;

    always_comb begin
        up_ready = '0;
        if (grant) begin
            up_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
            down_src   <= '0;
            state      <= ARB;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
        end else if (ld) begin
            down_valid <= grant;
            if (grant) begin
                down_data <= up_data[sel*D_WIDTH +: D_WIDTH];
                down_src  <= sel;
            end

            case (state)
                ARB: begin
                    if (grant) begin
                        ptr <= sel + 1'b1;
                        if (BURST > 1) begin
                            state <= LOCK;
                            owner <= sel;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                LOCK: begin
                    if (grant) begin
                        if (cnt_inc == BURST_C) begin
                            state <= ARB;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Owner went idle: give up the lock, ptr already
                        // points just past the owner.
                        state <= ARB;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ARB;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Drives two arbiters (BURST=4 and BURST=1) with shared random stimulus.
// A reference model predicts each grant and queues the expected output beat;
// a monitor pops and compares whenever an output beat is transferred.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int DW = 6;
    localparam int AW = 2;
    localparam int NR = 4;
    localparam int NCYC = 1400;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR*DW-1:0] ud  = '0;
    logic [NR-1:0]    uv  = '0;
    logic             dr  = 1'b0;

    logic [NR-1:0]    ur [2];
    logic [DW-1:0]    dd [2];
    logic [AW-1:0]    ds [2];
    logic             dv [2];

    int vectors     = 0;
    int miscompares = 0;

    // reference model state, index 0 = BURST 4, index 1 = BURST 1
    int  blen    [2] = '{4, 1};
    int  m_next  [2];
    int  m_owner [2];
    int  m_beats [2];
    bit  m_lock  [2];
    bit  m_full  [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    stream_rr_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .BURST(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .up_data    (ud),
        .up_valid   (uv),
        .up_ready   (ur[0]),
        .down_data  (dd[0]),
        .down_src   (ds[0]),
        .down_valid (dv[0]),
        .down_ready (dr)
    );

    stream_rr_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .BURST(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .up_data    (ud),
        .up_valid   (uv),
        .up_ready   (ur[1]),
        .down_data  (dd[1]),
        .down_src   (ds[1]),
        .down_valid (dv[1]),
        .down_ready (dr)
    );

    task automatic check(input string name, input int d, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s burst=%0d t=%0t actual=%0h required=%0h", name, blen[d], $time, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_next[d]  = 0;
        m_owner[d] = 0;
        m_beats[d] = 0;
        m_lock[d]  = 1'b0;
        m_full[d]  = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    // Monitor: compares the output register against the oldest expected beat.
    initial begin
        logic [7:0] e;
        int sz;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    check("down_valid", d, int'(dv[d]), int'(m_full[d]));
                    if (m_full[d] && dr) begin
                        sz = (d == 0) ? q0.size() : q1.size();
                        if (sz == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL scoreboard_empty burst=%0d t=%0t actual=empty required=beat", blen[d], $time);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check("down_src",  d, int'(ds[d]), int'(e[7:6]));
                            check("down_data", d, int'(dd[d]), int'(e[5:0]));
                        end
                    end
                end
            end
        end
    end

    // Reference model: decides each cycle's grant from the arbitration rules.
    initial begin
        int  g;
        bit  ld;
        for (int d = 0; d < 2; d++) model_reset(d);
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    check("rst_up_ready",   d, int'(ur[d]), 0);
                    check("rst_down_valid", d, int'(dv[d]), 0);
                    model_reset(d);
                end else begin
                    g  = -1;
                    ld = !m_full[d] || dr;
                    if (ld) begin
                        if (m_lock[d]) begin
                            if (uv[m_owner[d]]) begin
                                g = m_owner[d];
                                m_beats[d]++;
                                if (m_beats[d] == blen[d]) m_lock[d] = 1'b0;
                            end else begin
                                m_lock[d] = 1'b0;
                            end
                        end else begin
                            for (int k = 0; k < NR; k++) begin
                                if (g < 0 && uv[(m_next[d] + k) % NR]) g = (m_next[d] + k) % NR;
                            end
                            if (g >= 0) begin
                                m_next[d] = (g + 1) % NR;
                                if (blen[d] > 1) begin
                                    m_lock[d]  = 1'b1;
                                    m_owner[d] = g;
                                    m_beats[d] = 1;
                                end
                            end
                        end
                        m_full[d] = (g >= 0);
                    end
                    check("up_ready", d, int'(ur[d]), (g >= 0) ? (1 << g) : 0);
                    if (g >= 0) begin
                        if (d == 0) q0.push_back({2'(g), ud[g*DW +: DW]});
                        else        q1.push_back({2'(g), ud[g*DW +: DW]});
                    end
                end
            end
        end
    end

    // Stimulus driver.
    initial begin
        logic [NR-1:0] flip;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            ud = {$urandom, $urandom};
            if (c < 3) begin
                rst = 1'b0;
                uv  = '0;
                dr  = 1'b1;
            end else if (c < 6) begin
                rst = 1'b1;
                uv  = (c == 3) ? 4'b0100 : 4'b0000;
                ud[2*DW +: DW] = 6'h15;
                dr  = 1'b1;
            end else if (c < 60) begin
                uv = 4'b1111;
                dr = 1'b1;
            end else if (c < 400) begin
                uv = NR'($urandom);
                dr = ($urandom_range(3, 0) != 0);
            end else if (c < 600) begin
                for (int i = 0; i < NR; i++) flip[i] = ($urandom_range(9, 0) == 0);
                uv = uv ^ flip;
                dr = ($urandom_range(9, 0) != 0);
            end else if (c < 620) begin
                rst = (c == 610 || c == 611) ? 1'b0 : 1'b1;
                uv  = 4'b1111;
                dr  = 1'b1;
            end else begin
                for (int i = 0; i < NR; i++) uv[i] = ($urandom_range(9, 0) < 7);
                dr = $urandom_range(1, 0) != 0;
            end
        end
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
